// File: rtl/lab1_imul_resp_accum_pkg.sv
// ============================================================================
// Package : lab1_imul_resp_accum_pkg
// Shared lab1-imul message types: multiplier request/response and the
// accumulated-sum response {overflow, sum} at the default 32-bit width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lab1_imul_resp_accum_pkg;

    // Multiplier request: two operands
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } lab1_imul_req_msg_t;

    // Multiplier response: product
    typedef struct packed {
        logic [31:0] result;
    } lab1_imul_resp_msg_t;

    // Accumulator response: sticky carry flag above the wrapped sum
    typedef struct packed {
        logic        overflow;
        logic [31:0] sum;
    } lab1_imul_accum_msg_t;

endpackage

`default_nettype wire

// File: rtl/lab1_imul_resp_accum_dpath.sv
// ============================================================================
// Module  : lab1_imul_resp_accum_dpath
// Datapath of the response accumulator: sum register, adder with carry out,
// sticky overflow flag and burst down counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lab1_imul_resp_accum_dpath
    import lab1_imul_resp_accum_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,       // async, active-low
    input  logic                   clear_i,     // load counter, zero sum/overflow
    input  logic [p_len_nbits-1:0] len_i,
    input  logic                   acc_i,       // accept one product
    input  logic [p_nbits-1:0]     result_i,
    output logic                   cnt_is_one_o,
    output logic [p_len_nbits-1:0] cnt_o,
    output logic [p_nbits-1:0]     sum_o,
    output logic                   overflow_o
);

    localparam logic [p_len_nbits-1:0] c_cnt_one  = {{(p_len_nbits-1){1'b0}}, 1'b1};
    localparam logic [p_len_nbits-1:0] c_cnt_zero = '0;

    logic [p_len_nbits-1:0] cnt_q, cnt_d;
    logic [p_nbits-1:0]     sum_q, sum_d;
    logic                   ovf_q, ovf_d;
    logic [p_nbits:0]       add_w;

    // Extra top bit of the adder is the carry out of the sum MSB
    assign add_w = {1'b0, sum_q} + {1'b0, result_i};

    // Next-state: clear on config, accumulate and count down on each product
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = len_i;
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (acc_i) begin
            sum_d = add_w[p_nbits-1:0];
            ovf_d = ovf_q | add_w[p_nbits];
            // Saturate at zero so a stray accept can never wrap the counter
            cnt_d = (cnt_q != c_cnt_zero) ? (cnt_q - c_cnt_one) : cnt_q;
        end
    end

    // Datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_is_one_o = (cnt_q == c_cnt_one);
    assign cnt_o        = cnt_q;
    assign sum_o        = sum_q;
    assign overflow_o   = ovf_q;

endmodule

`default_nettype wire

// File: rtl/lab1_imul_resp_accum.sv
// ============================================================================
// Module  : lab1_imul_resp_accum
// Accumulates a configured-length burst of multiplier products and emits
// {overflow, sum}. Three-state control FSM; datapath in a sub-module.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lab1_imul_resp_accum
    import lab1_imul_resp_accum_pkg::*;
#(
    parameter int p_nbits     = 32,
    parameter int p_len_nbits = 8
) (
    input  logic                   clk,
    input  logic                   reset,      // async, active-low
    input  logic                   cfg_val,
    output logic                   cfg_rdy,
    input  logic [p_len_nbits-1:0] cfg_len,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_nbits-1:0]     in_result,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_nbits:0]       out_msg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                   cfg_go, in_go, out_go;
    logic                   cnt_is_one;
    logic [p_len_nbits-1:0] cnt;
    logic [p_nbits-1:0]     sum;
    logic                   overflow;

    // Ready/valid are pure functions of state, never of the partner's valid
    assign cfg_rdy = (state_q == IDLE);
    assign in_rdy  = (state_q == ACCUM);
    assign out_val = (state_q == DONE);

    assign cfg_go = cfg_val & cfg_rdy;
    assign in_go  = in_val  & in_rdy;
    assign out_go = out_val & out_rdy;

    lab1_imul_resp_accum_dpath #(
        .p_nbits     (p_nbits),
        .p_len_nbits (p_len_nbits)
    ) u_dpath (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (cfg_go),
        .len_i        (cfg_len),
        .acc_i        (in_go),
        .result_i     (in_result),
        .cnt_is_one_o (cnt_is_one),
        .cnt_o        (cnt),
        .sum_o        (sum),
        .overflow_o   (overflow)
    );

    // Sum register drives the message directly so it holds under backpressure
    assign out_msg = {overflow, sum};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_go) state_d = (cfg_len == '0) ? DONE : ACCUM;
            ACCUM:   if (in_go && cnt_is_one) state_d = DONE;
            DONE:    if (out_go) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Counter value is observed only by the line trace below
    logic [p_len_nbits-1:0] trace_cnt_w;
    assign trace_cnt_w = cnt;

    // Line trace: state, remaining count and running sum
`ifdef LINE_TRACE
    always_ff @(posedge clk) begin
        if (reset)
            $write("%s cnt=%0d sum=%h\n", state_q.name(), trace_cnt_w, sum);
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lab1_imul_resp_accum.sv
`default_nettype none

module tb_lab1_imul_resp_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [7:0]  cfg_len;
    logic        in_val;
    logic        in_rdy;
    logic [31:0] in_result;
    logic        out_val;
    logic        out_rdy;
    logic [32:0] out_msg;

    int n_vec = 0;
    int n_err = 0;

    lab1_imul_resp_accum dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_val   (cfg_val),
        .cfg_rdy   (cfg_rdy),
        .cfg_len   (cfg_len),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_result (in_result),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] len);
        int n = 0;
        cfg_val = 1'b1;
        cfg_len = len;
        while (!cfg_rdy && n < 50) begin tick(); n++; end
        if (n >= 50) chk("cfg_timeout", 0, 1);
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic send(input logic [31:0] p);
        int n = 0;
        in_val    = 1'b1;
        in_result = p;
        while (!in_rdy && n < 50) begin tick(); n++; end
        if (n >= 50) chk("in_timeout", 0, 1);
        tick();
        in_val = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [32:0] exp, input int stall);
        int n = 0;
        while (!out_val && n < 50) begin tick(); n++; end
        if (n >= 50) chk("out_timeout", 0, 1);
        for (int i = 0; i < stall; i++) tick();
        chk(tag, out_msg, exp);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    logic [32:0] acc;
    logic        ovf;
    int          len;
    logic [31:0] p;

    initial begin
        cfg_val = 0; cfg_len = 0; in_val = 0; in_result = 0; out_rdy = 0;
        reset = 1'b0;
        #1;
        chk("rst_cfg_rdy", cfg_rdy, 1);
        chk("rst_in_rdy",  in_rdy,  0);
        chk("rst_out_val", out_val, 0);
        chk("rst_msg",     out_msg, 0);
        tick(); tick();
        reset = 1'b1;
        #2;

        // Nominal burst
        do_cfg(3);
        chk("nom_in_rdy", in_rdy, 1);
        send(6); send(20);
        chk("nom_not_done", out_val, 0);
        send(42);
        chk("nom_out_val", out_val, 1);
        chk("nom_msg", out_msg, 33'd68);
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        chk("nom_idle", cfg_rdy, 1);
        chk("nom_hold", out_msg, 33'd68);

        // Zero length
        do_cfg(0);
        chk("zero_out_val", out_val, 1);
        chk("zero_in_rdy",  in_rdy,  0);
        chk("zero_msg",     out_msg, 33'd0);
        recv("zero_recv", 33'd0, 0);

        // Overflow
        do_cfg(2);
        send(32'hFFFF_FFF0); send(32'h20);
        recv("ovf_msg", {1'b1, 32'h10}, 0);

        // Bubbles and backpressure
        do_cfg(2);
        send(5);
        for (int i = 0; i < 3; i++) tick();
        chk("bub_in_rdy", in_rdy, 1);
        chk("bub_sum", out_msg, 33'd5);
        send(7);
        for (int i = 0; i < 4; i++) begin
            chk("bp_val", out_val, 1);
            chk("bp_msg", out_msg, 33'd12);
            chk("bp_cfg_rdy", cfg_rdy, 0);
            tick();
        end
        out_rdy = 1'b1; tick(); out_rdy = 1'b0;
        chk("bp_idle", cfg_rdy, 1);

        // Products offered in IDLE are ignored
        in_val = 1'b1; in_result = 32'd100;
        tick(); tick();
        chk("idle_in_rdy", in_rdy, 0);
        chk("idle_msg", out_msg, 33'd12);
        in_val = 1'b0;

        // Reset mid-burst, between clock edges
        do_cfg(4);
        send(1); send(2);
        #2 reset = 1'b0;
        #1;
        chk("mrst_cfg_rdy", cfg_rdy, 1);
        chk("mrst_in_rdy",  in_rdy,  0);
        chk("mrst_out_val", out_val, 0);
        chk("mrst_msg",     out_msg, 0);
        #3 reset = 1'b1;
        tick();
        chk("mrst_no_out", out_val, 0);
        do_cfg(1);
        send(9);
        recv("mrst_new", 33'd9, 0);

        // Maximum length: 255 ones
        do_cfg(8'd255);
        for (int i = 0; i < 254; i++) send(1);
        chk("max_not_done", out_val, 0);
        send(1);
        recv("max_msg", 33'd255, 0);

        // Random bursts with stalls against a reference model
        for (int b = 0; b < 500; b++) begin
            len = $urandom_range(0, 6);
            acc = 0; ovf = 0;
            do_cfg(len[7:0]);
            for (int k = 0; k < len; k++) begin
                p = ($urandom_range(0, 3) == 0) ? 32'hF000_0000 | $urandom : $urandom;
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                acc = {1'b0, acc[31:0]} + {1'b0, p};
                ovf = ovf | acc[32];
                send(p);
            end
            recv("rand_msg", {ovf, acc[31:0]}, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
